// File: rtl/seven_segment_reader.sv
// Receive-side 7-segment decoder: samples a multiplexed active-low segment/anode bus
// and recovers the hex nibble shown on each digit once the pattern has settled.
module seven_segment_reader #(
    parameter int NUM_DIGITS    = 4,
    parameter int STABLE_CYCLES = 16
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [6:0]              segments,
    input  logic [NUM_DIGITS-1:0]   anodes,
    output logic [4*NUM_DIGITS-1:0] value,
    output logic [NUM_DIGITS-1:0]   digit_valid,
    output logic                    update,
    output logic [2:0]              update_index,
    output logic                    invalid
);

    localparam int CW = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] TERM = CW'(STABLE_CYCLES - 1);
    localparam logic [6:0] BLANK = 7'h7F;

    typedef enum logic [1:0] {
        IDLE,
        SETTLING,
        HELD
    } state_t;

    state_t                state;
    logic [CW-1:0]         count;
    logic [6:0]            seg_meta;
    logic [6:0]            seg_sync;
    logic [6:0]            seg_prev;
    logic [NUM_DIGITS-1:0] an_meta;
    logic [NUM_DIGITS-1:0] an_sync;
    logic [NUM_DIGITS-1:0] an_prev;

    logic       changed;
    logic       no_anode;
    logic [3:0] low_count;
    int         sel;
    logic [4:0] decoded;
    logic       legal;
    logic [3:0] nibble;

    // Inverse of the team's hex-to-segment table; bit 4 flags a legal code.
    function automatic logic [4:0] decode(input logic [6:0] s);
        case (s)
            7'h40:   return {1'b1, 4'h0};
            7'h79:   return {1'b1, 4'h1};
            7'h24:   return {1'b1, 4'h2};
            7'h30:   return {1'b1, 4'h3};
            7'h19:   return {1'b1, 4'h4};
            7'h12:   return {1'b1, 4'h5};
            7'h02:   return {1'b1, 4'h6};
            7'h78:   return {1'b1, 4'h7};
            7'h00:   return {1'b1, 4'h8};
            7'h10:   return {1'b1, 4'h9};
            7'h08:   return {1'b1, 4'hA};
            7'h03:   return {1'b1, 4'hB};
            7'h46:   return {1'b1, 4'hC};
            7'h21:   return {1'b1, 4'hD};
            7'h06:   return {1'b1, 4'hE};
            7'h0E:   return {1'b1, 4'hF};
            default: return 5'b0_0000;
        endcase
    endfunction

    assign changed  = (seg_sync != seg_prev) || (an_sync != an_prev);
    assign no_anode = &an_sync;
    assign decoded  = decode(seg_sync);
    assign legal    = decoded[4];
    assign nibble   = decoded[3:0];

    // Count the active anodes and remember which one is low for the single-digit case.
    always_comb begin
        low_count = '0;
        sel       = 0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (!an_sync[i]) begin
                low_count = low_count + 4'd1;
                sel       = i;
            end
        end
    end

    // Synchronizer, stability FSM and the registered accept outputs.
    always_ff @(posedge clk) begin
        if (reset) begin
            seg_meta     <= BLANK;
            seg_sync     <= BLANK;
            seg_prev     <= BLANK;
            an_meta      <= '1;
            an_sync      <= '1;
            an_prev      <= '1;
            state        <= IDLE;
            count        <= '0;
            value        <= '0;
            digit_valid  <= '0;
            update       <= 1'b0;
            update_index <= 3'd0;
            invalid      <= 1'b0;
        end else begin
            seg_meta <= segments;
            seg_sync <= seg_meta;
            seg_prev <= seg_sync;
            an_meta  <= anodes;
            an_sync  <= an_meta;
            an_prev  <= an_sync;
            update   <= 1'b0;
            invalid  <= 1'b0;

            case (state)
                IDLE: begin
                    if (!no_anode) begin
                        state <= SETTLING;
                        count <= '0;
                    end
                end

                SETTLING: begin
                    if (changed) begin
                        count <= '0;
                        state <= no_anode ? IDLE : SETTLING;
                    end else if (count == TERM) begin
                        state <= HELD;
                        if (low_count == 4'd1) begin
                            if (legal) begin
                                value[4*sel +: 4] <= nibble;
                                digit_valid[sel]  <= 1'b1;
                                update            <= 1'b1;
                                update_index      <= 3'(sel);
                            end else if (seg_sync == BLANK) begin
                                digit_valid[sel]  <= 1'b0;
                                update            <= 1'b1;
                                update_index      <= 3'(sel);
                            end else begin
                                invalid <= 1'b1;
                            end
                        end else begin
                            invalid <= 1'b1;
                        end
                    end else begin
                        count <= count + 1'b1;
                    end
                end

                HELD: begin
                    if (changed) begin
                        count <= '0;
                        state <= no_anode ? IDLE : SETTLING;
                    end
                end

                default: begin
                    state <= IDLE;
                    count <= '0;
                end
            endcase
        end
    end

endmodule

// File: doc/seven_segment_reader.md
Name: seven_segment_reader

Overview:
- Receive-side counterpart to the team's hex-to-segment decoder.
- Samples an externally driven, time-multiplexed, active-low 7-segment bus (segments plus one-hot-low anodes) and recovers the 4-bit hex value shown on each digit.
- Used to observe display outputs from other boards or modules.
- Publishes the per-digit values with valid flags, an update strobe, and an illegal-pattern strobe.

Parameters:
- NUM_DIGITS, 4: number of multiplexed digits (anode lines); range 1..8.
- STABLE_CYCLES, 16: consecutive identical synchronized samples required before a pattern is accepted; range 2..65535.

Ports:
- Clk  input  1  system clock. One clock; reset is synchronous and active-high.
- Reset  input  1  synchronous, active-high reset.
- Segments  input  7  active-low segments; bit0=a … bit6=g (0 is 7'b1000000).
- Anodes  input  NUM_DIGITS  active-low digit enables; bit i selects digit i.
- Value  output  4*NUM_DIGITS  recovered nibbles; digit i occupies bits [4i+3:4i].
- DigitValid  output  NUM_DIGITS  bit i high means Value for digit i holds a decoded hex value.
- Update  output  1  one-cycle pulse when a digit slot is written or cleared.
- UpdateIndex  output  3  digit index for the current Update; holds its last value otherwise.
- Invalid  output  1  one-cycle pulse when an illegal pattern or anode combination is accepted.

Behaviour:
- Reset values:
  - Value=0, DigitValid=0, Update=0, Invalid=0, UpdateIndex=0.
  - Both synchronizer stages = all ones (blank, no anode).
  - Stability counter=0; state=IDLE.
- Synchronizer:
  - Segments and Anodes pass through two flop stages.
  - All decisions use the second stage (S, A) and the previous-cycle copy (S', A').
- "Change" means (S,A) != (S',A') in a cycle.
- States:
  - IDLE: A all ones. Leaves IDLE for SETTLING, with counter=0, in the first cycle A has any zero bit.
  - SETTLING:
    - Counter increments each cycle with no change.
    - On a change, counter reloads 0 and the state stays SETTLING, or goes to IDLE if the new A is all ones.
    - When the counter equals STABLE_CYCLES-1 with no change: perform an accept, then go to HELD.
  - HELD: stays until a change, then goes to SETTLING (counter 0) or IDLE. Exactly one accept per held pattern.
- Accept actions (outputs registered, visible the cycle after the accept):
  - Exactly one A bit low, S one of the 16 legal codes: Value[i] = decoded nibble; DigitValid[i]=1; Update=1; UpdateIndex=i. Legal codes are the same active-low table as the team decoder: 0=1000000 … 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110.
  - Exactly one A bit low, S=1111111 (blank): DigitValid[i]=0; Value[i] unchanged; Update=1; UpdateIndex=i; Invalid stays 0.
  - Exactly one A bit low, any other S: Invalid=1; Value, DigitValid and Update unchanged.
  - Two or more A bits low: Invalid=1; no slot written.
  - Update and Invalid are never high in the same cycle.
- Latency: when both inputs are constant from cycle t and differ from the prior pattern, the accept decision is made in cycle t+STABLE_CYCLES+1 and Update/Invalid are high in cycle t+STABLE_CYCLES+2.
- Counter width is clog2(STABLE_CYCLES); the counter never wraps, because the state leaves SETTLING at the terminal count.
- Reset asserted mid-SETTLING or in HELD aborts any pending accept. No Update follows reset until a fresh stable pattern has been held for the full STABLE_CYCLES after the synchronizer refills.
- Rewriting an identical value still pulses Update; the slot's value is unchanged.

Test Plan:
- Reset, then Anodes=1110, Segments=0110000 held 40 cycles -> one Update at t+18, UpdateIndex=0, Value[3:0]=3, DigitValid=0001, Invalid never high.
- Round-robin scan, 100 cycles per digit: digit0=F (0001110), 1=A (0001000), 2=0 (1000000), 3=7 (1111000) -> Value=16'h70AF, DigitValid=1111, Update once per digit per dwell.
- Anodes=1101 held 40 cycles with Segments toggling every 10 cycles, then stable 0000011 -> no accept during toggling; final Update index 1, Value[7:4]=B.
- Anodes=1011 with Segments=1111111 after digit 2 previously held 5 -> Update index 2, DigitValid[2]=0, Value[11:8]=5, Invalid=0.
- Segments=1010101 on Anodes=0111, then Segments=0010010 on Anodes=0011 -> Invalid pulses once per pattern, Update never high, Value and DigitValid unchanged.
- Reset asserted at counter=10 of an otherwise valid hold -> no Update; outputs at reset values; Update appears only STABLE_CYCLES+2 cycles after reset is released with the inputs still held.
